// File: rtl/factorial_host_master.sv
// factorial_host_master
// Bus initiator that runs one complete register transaction sequence on the
// factorial accelerator (write N, pulse GO, poll status, read result, clear
// GO) for every accepted request, and hands back the result with error and
// timeout flags on a response handshake.
module factorial_host_master #(
   parameter int TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [3:0]  req_n,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [31:0] resp_result,
   output logic        resp_err,
   output logic        resp_timeout,
   output logic        busy,
   output logic [1:0]  bus_addr,
   output logic        bus_we,
   output logic [3:0]  bus_wd,
   input  logic [31:0] bus_rd
);

   localparam int CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);

   localparam logic [1:0] ADDR_N      = 2'd0;
   localparam logic [1:0] ADDR_GO     = 2'd1;
   localparam logic [1:0] ADDR_STATUS = 2'd2;
   localparam logic [1:0] ADDR_RESULT = 2'd3;

   typedef enum logic [2:0] {
      IDLE,
      WR_N,
      WR_GO,
      SETTLE,
      POLL,
      RD_RES,
      CLR_GO,
      RESP
   } state_t;

   state_t            state;
   state_t            state_next;
   logic [3:0]        n_q;
   logic [CNT_W-1:0]  poll_cnt;
   logic [CNT_W-1:0]  poll_cnt_inc;
   logic [31:0]       result_q;
   logic              err_q;
   logic              timeout_q;
   logic              status_err;
   logic              status_done;

   assign status_err  = bus_rd[1];
   assign status_done = bus_rd[0];

   // Saturating increment so the poll counter can never wrap back to zero.
   always_comb begin
      poll_cnt_inc = poll_cnt;
      if (poll_cnt != TIMEOUT_CNT) begin
         poll_cnt_inc = poll_cnt + CNT_W'(1);
      end
   end

   // State register; reset always lands in IDLE so no write is left pending.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic: walks the fixed register sequence, leaving POLL early
   // on error (which wins over done), on done, or when the poll budget is spent.
   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (req_valid) begin
               state_next = WR_N;
            end
         end
         WR_N:   state_next = WR_GO;
         WR_GO:  state_next = SETTLE;
         SETTLE: state_next = POLL;
         POLL: begin
            if (status_err) begin
               state_next = CLR_GO;
            end else if (status_done) begin
               state_next = RD_RES;
            end else if (poll_cnt_inc == TIMEOUT_CNT) begin
               state_next = CLR_GO;
            end
         end
         RD_RES: state_next = CLR_GO;
         CLR_GO: state_next = RESP;
         RESP: begin
            if (resp_ready) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Bus drive decoded purely from the current state; IDLE parks on the
   // status register with no write strobe.
   always_comb begin
      bus_addr = ADDR_STATUS;
      bus_we   = 1'b0;
      bus_wd   = 4'd0;
      case (state)
         WR_N: begin
            bus_addr = ADDR_N;
            bus_we   = 1'b1;
            bus_wd   = n_q;
         end
         WR_GO: begin
            bus_addr = ADDR_GO;
            bus_we   = 1'b1;
            bus_wd   = 4'b0001;
         end
         RD_RES: begin
            bus_addr = ADDR_RESULT;
         end
         CLR_GO: begin
            bus_addr = ADDR_GO;
            bus_we   = 1'b1;
            bus_wd   = 4'd0;
         end
         default: begin
            bus_addr = ADDR_STATUS;
         end
      endcase
   end

   // Operand, poll counter and response registers. Flags and result are
   // cleared at acceptance so each response reflects only its own run.
   always_ff @(posedge clk) begin
      if (!rst) begin
         n_q       <= 4'd0;
         poll_cnt  <= '0;
         result_q  <= 32'd0;
         err_q     <= 1'b0;
         timeout_q <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (req_valid) begin
                  n_q       <= req_n;
                  poll_cnt  <= '0;
                  result_q  <= 32'd0;
                  err_q     <= 1'b0;
                  timeout_q <= 1'b0;
               end
            end
            POLL: begin
               if (status_err) begin
                  err_q    <= 1'b1;
                  result_q <= 32'd0;
               end else if (!status_done) begin
                  poll_cnt <= poll_cnt_inc;
                  if (poll_cnt_inc == TIMEOUT_CNT) begin
                     timeout_q <= 1'b1;
                     result_q  <= 32'd0;
                  end
               end
            end
            RD_RES: begin
               result_q <= bus_rd;
            end
            default: begin
            end
         endcase
      end
   end

   assign req_ready    = (state == IDLE);
   assign busy         = (state != IDLE);
   assign resp_valid   = (state == RESP);
   assign resp_result  = result_q;
   assign resp_err     = err_q;
   assign resp_timeout = timeout_q;

endmodule

// File: tb/tb_factorial_host_master.sv
// tb_factorial_host_master
// Drives requests into the host master against a behavioural factorial
// accelerator and checks responses through a scoreboard queue.
module tb_factorial_host_master;

   localparam int TIMEOUT = 16;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic [3:0]  req_n;
   logic        resp_valid;
   logic        resp_ready;
   logic [31:0] resp_result;
   logic        resp_err;
   logic        resp_timeout;
   logic        busy;
   logic [1:0]  bus_addr;
   logic        bus_we;
   logic [3:0]  bus_wd;
   logic [31:0] bus_rd;

   int vectors = 0;
   int miscompares = 0;

   typedef struct {
      logic [31:0] result;
      logic        err;
      logic        tmo;
      int          lat;
      int          polls;
   } exp_t;

   exp_t sb[$];

   factorial_host_master #(.TIMEOUT(TIMEOUT)) dut (
      .clk          (clk),
      .rst          (rst),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_n        (req_n),
      .resp_valid   (resp_valid),
      .resp_ready   (resp_ready),
      .resp_result  (resp_result),
      .resp_err     (resp_err),
      .resp_timeout (resp_timeout),
      .busy         (busy),
      .bus_addr     (bus_addr),
      .bus_we       (bus_we),
      .bus_wd       (bus_wd),
      .bus_rd       (bus_rd)
   );

   // Free-running clock
   always #5 clk = ~clk;

   function automatic logic [63:0] fact64(input int n);
      logic [63:0] f;
      f = 64'd1;
      for (int i = 2; i <= n; i++) begin
         f = f * 64'(i);
      end
      return f;
   endfunction

   // Behavioural accelerator: status asserts done (or err on 32-bit overflow)
   // done_delay cycles after GO is written to 1.
   logic [3:0]  acc_n = 4'd0;
   logic        acc_go = 1'b0;
   int          acc_cyc = 0;
   int          done_delay = 3;
   bit          never_done = 1'b0;
   logic [63:0] acc_fact;
   logic        acc_fin;
   logic        acc_err;
   logic        acc_done;

   // Register writes and the cycle count since GO
   always @(posedge clk) begin
      if (bus_we) begin
         if (bus_addr == 2'd0) begin
            acc_n <= bus_wd;
         end else if (bus_addr == 2'd1) begin
            acc_go  <= bus_wd[0];
            acc_cyc <= 0;
         end
      end else if (acc_go) begin
         acc_cyc <= acc_cyc + 1;
      end
   end

   assign acc_fact = fact64(int'(acc_n));
   assign acc_fin  = acc_go && !never_done && (acc_cyc >= done_delay);
   assign acc_err  = acc_fin && (acc_fact > 64'h0000_0000_FFFF_FFFF);
   assign acc_done = acc_fin && !acc_err;

   // Combinational read data for the addressed register
   always_comb begin
      bus_rd = 32'd0;
      case (bus_addr)
         2'd0: bus_rd = {28'd0, acc_n};
         2'd1: bus_rd = {31'd0, acc_go};
         2'd2: bus_rd = {30'd0, acc_err, acc_done};
         2'd3: bus_rd = acc_fact[31:0];
         default: bus_rd = 32'd0;
      endcase
   end

   task automatic checkOutput(input string tag, input logic [63:0] actual,
                              input logic [63:0] expected);
      vectors++;
      if (actual !== expected) begin
         miscompares++;
         $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
      end
   endtask

   // One full request: handshake in, watch the bus, optionally stall the
   // response, then compare against the scoreboard entry.
   task automatic applyStimulus(input logic [3:0] n, input int hold);
      exp_t        e;
      exp_t        got;
      logic [63:0] f;
      int          guard;
      int          j;
      int          reads2;
      int          rd3;
      int          clr;
      int          we_viol;
      int          wrn_ok;
      int          hold_bad;
      logic        prev_we;
      logic [1:0]  prev_addr;
      logic [31:0] snap;

      guard = 0;
      while (!req_ready && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      if (!req_ready) begin
         checkOutput("accept_bound", 0, 1);
         return;
      end
      req_valid = 1'b1;
      req_n     = n;
      f = fact64(int'(n));
      if (never_done) begin
         e.result = 32'd0; e.err = 1'b0; e.tmo = 1'b1;
         e.lat = 5 + TIMEOUT; e.polls = TIMEOUT;
      end else if (f > 64'h0000_0000_FFFF_FFFF) begin
         e.result = 32'd0; e.err = 1'b1; e.tmo = 1'b0;
         e.lat = 5 + done_delay; e.polls = done_delay;
      end else begin
         e.result = f[31:0]; e.err = 1'b0; e.tmo = 1'b0;
         e.lat = 6 + done_delay; e.polls = done_delay;
      end
      sb.push_back(e);

      @(negedge clk);
      req_valid = 1'b0;
      req_n     = ~n;
      j = 1; reads2 = 0; rd3 = 0; clr = 0; we_viol = 0; wrn_ok = 0;
      prev_we = 1'b0; prev_addr = 2'd2;
      while (!resp_valid && j < 200) begin
         if (j == 1 && bus_we && bus_addr == 2'd0 && bus_wd == n) wrn_ok = 1;
         if (bus_we && prev_we && !(prev_addr == 2'd0 && bus_addr == 2'd1)) we_viol++;
         if (!bus_we && bus_addr == 2'd2) reads2++;
         if (!bus_we && bus_addr == 2'd3) rd3++;
         if (bus_we && bus_addr == 2'd1 && bus_wd == 4'd0) clr++;
         prev_we   = bus_we;
         prev_addr = bus_addr;
         @(negedge clk);
         j++;
      end
      got = sb.pop_front();
      if (!resp_valid) begin
         checkOutput("resp_bound", 0, 1);
         return;
      end
      checkOutput("latency", j, got.lat);
      checkOutput("poll_cycles", reads2 - 1, got.polls);
      checkOutput("rd_result_reads", rd3, (got.err || got.tmo) ? 0 : 1);
      checkOutput("clr_go_writes", clr, 1);
      checkOutput("we_back_to_back", we_viol, 0);
      checkOutput("wr_n_first", wrn_ok, 1);
      checkOutput("acc_n_written", acc_n, n);
      checkOutput("acc_go_cleared", acc_go, 0);

      resp_ready = 1'b0;
      hold_bad = 0;
      snap = resp_result;
      for (int i = 0; i < hold; i++) begin
         if (!resp_valid || resp_result !== snap || req_ready || !busy) hold_bad++;
         @(negedge clk);
      end
      if (hold > 0) checkOutput("hold_stable", hold_bad, 0);

      checkOutput("resp_result", resp_result, got.result);
      checkOutput("resp_err", resp_err, got.err);
      checkOutput("resp_timeout", resp_timeout, got.tmo);
      resp_ready = 1'b1;
      @(negedge clk);
      resp_ready = 1'b0;
      checkOutput("resp_released", resp_valid, 0);
      checkOutput("idle_gap_ready", req_ready, 1);
   endtask

   // Main sequence
   initial begin
      rst = 1'b0; req_valid = 1'b0; req_n = 4'd0; resp_ready = 1'b0;
      repeat (3) @(negedge clk);
      checkOutput("rst_req_ready", req_ready, 1);
      checkOutput("rst_resp_valid", resp_valid, 0);
      checkOutput("rst_busy", busy, 0);
      checkOutput("rst_bus", {bus_addr, bus_we, bus_wd}, {2'd2, 1'b0, 4'd0});
      checkOutput("rst_resp", {resp_result, resp_err, resp_timeout}, 34'd0);
      rst = 1'b1;
      @(negedge clk);

      applyStimulus(4'd5, 0);
      applyStimulus(4'd0, 0);
      applyStimulus(4'd1, 0);
      applyStimulus(4'd13, 0);
      never_done = 1'b1;
      applyStimulus(4'd9, 0);
      never_done = 1'b0;
      applyStimulus(4'd7, 10);
      applyStimulus(4'd12, 0);

      done_delay = 100;
      req_valid = 1'b1; req_n = 4'd6;
      @(negedge clk);
      req_valid = 1'b0;
      repeat (4) @(negedge clk);
      checkOutput("abort_in_poll", {busy, bus_addr, bus_we}, {1'b1, 2'd2, 1'b0});
      rst = 1'b0;
      @(negedge clk);
      checkOutput("abort_req_ready", req_ready, 1);
      checkOutput("abort_busy", busy, 0);
      checkOutput("abort_bus", {bus_addr, bus_we, bus_wd}, {2'd2, 1'b0, 4'd0});
      checkOutput("abort_resp", {resp_valid, resp_result, resp_err, resp_timeout}, 35'd0);
      rst = 1'b1;
      done_delay = 3;
      repeat (3) begin
         @(negedge clk);
         if (resp_valid) checkOutput("abort_no_resp", resp_valid, 0);
      end
      applyStimulus(4'd4, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   // Watchdog so the run always ends
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule

// File: doc/factorial_host_master.md
# factorial_host_master

Bus initiator that drives the memory-mapped factorial accelerator register interface from the controller side. Accepts a request carrying a 4-bit n on a valid/ready handshake, then runs the full register sequence on the accelerator's 2-bit address bus: write N, pulse GO, poll status until done or error, read the result, clear GO. Returns the 32-bit result with error and timeout flags on a second valid/ready handshake. Sits between the datapath or test sequencer and the factorial wrapper, connected wire-for-wire to its addr/we/wd/rd ports.

## Interface
- TIMEOUT, 255: maximum POLL cycles before abandoning the run. Must be ≥1.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous reset, active-low; sampled on the clk rising edge.
- req_valid  in  1  request present.
- req_ready  out  1  master can accept; high only in IDLE.
- req_n  in  4  operand n; captured at the handshake.
- resp_valid  out  1  response present.
- resp_ready  in  1  consumer accepts the response.
- resp_result  out  32  n!; 0 when resp_err or resp_timeout is set.
- resp_err  out  1  accelerator reported an error.
- resp_timeout  out  1  no done or error within TIMEOUT polls.
- busy  out  1  high in every state except IDLE.
- bus_addr  out  2  register address: 0=N, 1=GO, 2=status {err,done}, 3=result.
- bus_we  out  1  write strobe, one cycle per write.
- bus_wd  out  4  write data.
- bus_rd  in  32  combinational read data for bus_addr in the same cycle.

## Operation
- States: IDLE, WR_N, WR_GO, SETTLE, POLL, RD_RES, CLR_GO, RESP.
- IDLE: bus_addr=2, bus_we=0, bus_wd=0. On req_valid&req_ready, capture req_n, clear the poll counter and flags, go to WR_N.
- WR_N: addr=0, we=1, wd=n_q. Go to WR_GO.
- WR_GO: addr=1, we=1, wd=4'b0001. Go to SETTLE.
- SETTLE: addr=2, we=0. bus_rd is ignored, because the status bits from the previous run are still clearing. Go to POLL.
- POLL: addr=2, we=0. Sample bus_rd[1] (err) and bus_rd[0] (done).
  - err=1: set err_q, result_q=0, go to CLR_GO. Error has priority when err and done are both 1.
  - else done=1: go to RD_RES.
  - else poll counter +1. When the counter reaches TIMEOUT, set timeout_q, result_q=0, go to CLR_GO.
- RD_RES: addr=3, we=0. result_q ← bus_rd. Go to CLR_GO.
- CLR_GO: addr=1, we=1, wd=0. This leaves the GO register at 0. Go to RESP.
- RESP: resp_valid=1. resp_result, resp_err and resp_timeout come from registers and stay stable until resp_valid&resp_ready, then go to IDLE.
- Poll counter width: $clog2(TIMEOUT+1). It saturates and never wraps.
- req_n changes after acceptance have no effect.

## Timing
- All outputs are registered or decoded from the state register only. There is no combinational path from req_* or resp_ready to any output.
- Reset values: state=IDLE, req_ready=1, resp_valid=0, resp_result=0, resp_err=0, resp_timeout=0, busy=0, bus_addr=2, bus_we=0, bus_wd=0.
- Cycle 0 is the accept edge. Bus sequence:
  - c1: WR_N
  - c2: WR_GO
  - c3: SETTLE
  - c4…c(3+k): POLL, where k is the number of POLL cycles, ≥1
  - then RD_RES (skipped on error or timeout)
  - then CLR_GO
  - then RESP
- Success latency from accept edge to resp_valid high: 6+k cycles. Error/timeout latency: 5+k cycles.
- Back-to-back requests: at least one IDLE cycle between the RESP handshake and the next accept.
- Reset mid-operation: the FSM returns to IDLE and bus_we drops within that same edge. No response is produced for the aborted request. The next request fully rewrites N and GO.
- bus_we is never high in two consecutive cycles except WR_N→WR_GO.

## Test plan
- Behavioural accelerator model (done 3 cycles after GO), req_n=5 → writes N=5, GO=1, then GO=0. resp_result=120, err=0, timeout=0. resp_valid rises 9 cycles after accept (k=3).
- req_n=0, then req_n=1 back-to-back → resp_result=1 both times. The second request is accepted only after the first RESP handshake plus one IDLE cycle.
- req_n=13 with the model asserting err → resp_err=1, resp_result=0. No address-3 read appears on the bus. A CLR_GO write still occurs.
- Model never asserts done, TIMEOUT=16 → exactly 16 POLL cycles, then resp_timeout=1, resp_result=0, then GO cleared.
- n=7 with resp_ready held low 10 cycles after resp_valid → outputs stay stable at 5040, req_ready=0, busy=1. The response completes on the cycle resp_ready rises.
- rst low during POLL → on the next edge all outputs equal their reset values. A following request with n=4 returns 24.
